matrix_host_port: RTL and testbench



---
 rtl/matrix_host_port_if.sv | 31 +++
 rtl/matrix_host_port.sv | 130 +++++++++++++
 tb/tb_matrix_host_port.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_host_port_if.sv
// Host/core bundle for matrix_host_port: serial load and store streams plus the flat operand/result buses.
// slave = the port block, master = host and core side.
interface matrix_host_port_if #(
  parameter int size_square = 16,
  parameter int width       = 32
);
  logic [width-1:0]             in_load_data;
  logic                         in_load_stb;
  logic                         out_load_ack;
  logic [width-1:0]             out_store_data;
  logic                         out_store_stb;
  logic                         in_store_ack;
  logic [width*size_square-1:0] out_matrix_a;
  logic [width*size_square-1:0] out_matrix_b;
  logic                         out_core_start;
  logic [width*size_square-1:0] in_matrix_c;
  logic                         in_core_done;
  logic                         out_busy;

  modport slave (
    input  in_load_data, in_load_stb, in_store_ack, in_matrix_c, in_core_done,
    output out_load_ack, out_store_data, out_store_stb, out_matrix_a, out_matrix_b,
           out_core_start, out_busy
  );

  modport master (
    output in_load_data, in_load_stb, in_store_ack, in_matrix_c, in_core_done,
    input  out_load_ack, out_store_data, out_store_stb, out_matrix_a, out_matrix_b,
           out_core_start, out_busy
  );
endinterface

// File: rtl/matrix_host_port.sv
// Host front end for the matrix multiply core: loads A then B serially, pulses start,
// captures C on core done and streams it back. One element per cycle; strobe/ack stalls hold state.
module matrix_host_port #(
  parameter int size        = 4,
  parameter int size_square = 16,
  parameter int width       = 32
) (
  input  logic              in_clk,
  input  logic              in_reset,
  matrix_host_port_if.slave host
);

  localparam int IDX_W = (size_square > 1) ? $clog2(size_square) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(size * size - 1);

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT,
    S_STORE
  } state_t;

  state_t                       r_state;
  logic [IDX_W-1:0]             r_idx;
  logic [width*size_square-1:0] r_a;
  logic [width*size_square-1:0] r_b;
  logic [width*size_square-1:0] r_c;
  logic [width-1:0]             r_store_data;
  logic                         r_load_ack;
  logic                         r_core_start;
  logic                         r_store_stb;
  logic                         r_busy;

  logic [IDX_W-1:0]             w_idx_nxt;
  logic                         w_last;

  assign w_idx_nxt = r_idx + 1'b1;
  assign w_last    = (r_idx == LAST);

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_state      <= S_LOAD_A;
      r_idx        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_store_data <= '0;
      r_load_ack   <= 1'b1;
      r_core_start <= 1'b0;
      r_store_stb  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD_A: begin
          if (host.in_load_stb) begin
            r_a[r_idx*width +: width] <= host.in_load_data;
            if (w_last) begin
              r_idx   <= '0;
              r_state <= S_LOAD_B;
            end else begin
              r_idx <= w_idx_nxt;
            end
          end
        end
        S_LOAD_B: begin
          if (host.in_load_stb) begin
            r_b[r_idx*width +: width] <= host.in_load_data;
            if (w_last) begin
              // ack drops and start rises together so no extra element slips in
              r_idx        <= '0;
              r_state      <= S_START;
              r_load_ack   <= 1'b0;
              r_core_start <= 1'b1;
              r_busy       <= 1'b1;
            end else begin
              r_idx <= w_idx_nxt;
            end
          end
        end
        S_START: begin
          r_core_start <= 1'b0;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          if (host.in_core_done) begin
            r_c          <= host.in_matrix_c;
            r_idx        <= '0;
            r_store_data <= host.in_matrix_c[width-1:0];
            r_store_stb  <= 1'b1;
            r_state      <= S_STORE;
          end
        end
        S_STORE: begin
          if (host.in_store_ack) begin
            if (w_last) begin
              r_idx        <= '0;
              r_store_stb  <= 1'b0;
              r_store_data <= '0;
              r_busy       <= 1'b0;
              r_load_ack   <= 1'b1;
              r_state      <= S_LOAD_A;
            end else begin
              // prefetch the next element so the output stays a pure register
              r_idx        <= w_idx_nxt;
              r_store_data <= r_c[w_idx_nxt*width +: width];
            end
          end
        end
        default: begin
          r_state      <= S_LOAD_A;
          r_idx        <= '0;
          r_load_ack   <= 1'b1;
          r_core_start <= 1'b0;
          r_store_stb  <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign host.out_load_ack   = r_load_ack;
  assign host.out_store_data = r_store_data;
  assign host.out_store_stb  = r_store_stb;
  assign host.out_matrix_a   = r_a;
  assign host.out_matrix_b   = r_b;
  assign host.out_core_start = r_core_start;
  assign host.out_busy       = r_busy;

endmodule

// File: tb/tb_matrix_host_port.sv
// Directed bench for matrix_host_port at N=2 with a stub core that multiplies by a 0/1.0 permutation A.
module tb_matrix_host_port;

  localparam int N  = 2;
  localparam int NN = 4;
  localparam int W  = 32;

  localparam logic [31:0] F0 = 32'h0000_0000;
  localparam logic [31:0] F1 = 32'h3F80_0000;
  localparam logic [31:0] F2 = 32'h4000_0000;
  localparam logic [31:0] F3 = 32'h4040_0000;
  localparam logic [31:0] F4 = 32'h4080_0000;
  localparam logic [31:0] F5 = 32'h40A0_0000;
  localparam logic [31:0] F6 = 32'h40C0_0000;
  localparam logic [31:0] F7 = 32'h40E0_0000;
  localparam logic [31:0] F8 = 32'h4100_0000;

  logic clk;
  logic rst;
  logic force_done;
  logic stub_done;
  logic stub_run;
  int   stub_cnt;
  int   done_len;
  int   start_cnt;
  logic [W*NN-1:0] stub_c;
  logic [W*NN-1:0] stub_prod;

  int vectors;
  int miscompares;

  matrix_host_port_if #(.size_square(NN), .width(W)) bus ();

  matrix_host_port #(.size(N), .size_square(NN), .width(W)) dut (
    .in_clk  (clk),
    .in_reset(rst),
    .host    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A is restricted to 0 / 1.0 entries, so A x B reduces to selecting rows of B
  function automatic logic [W*NN-1:0] perm_mul(input logic [W*NN-1:0] a, input logic [W*NN-1:0] b);
    logic [W*NN-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++)
          if (a[(i*N+k)*W +: W] == F1) c[(i*N+j)*W +: W] = c[(i*N+j)*W +: W] | b[(k*N+j)*W +: W];
    return c;
  endfunction

  // Stub core: done rises 5 cycles after start; extra done cycles present corrupted data
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_run  <= 1'b0;
      stub_cnt  <= 0;
      stub_done <= 1'b0;
      stub_c    <= '0;
      stub_prod <= '0;
    end else if (bus.out_core_start) begin
      stub_run  <= 1'b1;
      stub_cnt  <= 0;
      stub_done <= 1'b0;
      stub_prod <= perm_mul(bus.out_matrix_a, bus.out_matrix_b);
    end else if (stub_run) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt == 3) begin
        stub_done <= 1'b1;
        stub_c    <= stub_prod;
      end else if (stub_cnt > 3 && stub_cnt < 3 + done_len) begin
        stub_c <= ~stub_prod;
      end else if (stub_cnt >= 3 + done_len) begin
        stub_done <= 1'b0;
        stub_run  <= 1'b0;
      end
    end
  end

  always @(posedge clk) if (bus.out_core_start === 1'b1) start_cnt <= start_cnt + 1;

  assign bus.in_core_done = stub_done | force_done;
  assign bus.in_matrix_c  = stub_c;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_load_stb  = 1'b0;
    bus.in_store_ack = 1'b0;
    bus.in_load_data = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Entered and left on a negedge; the transfer happens on the posedge in between.
  task automatic push(input logic [31:0] d, input bit bp);
    int guard;
    guard = 0;
    if (bp) while ($urandom_range(0, 1) == 1) begin
      bus.in_load_stb = 1'b0;
      @(negedge clk);
    end
    bus.in_load_data = d;
    bus.in_load_stb  = 1'b1;
    while (bus.out_load_ack !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (bus.out_load_ack !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL load_timeout: ack=%b required 1", bus.out_load_ack);
    end
    @(negedge clk);
    bus.in_load_stb = 1'b0;
  endtask

  task automatic load_job(input logic [W*NN-1:0] a, input logic [W*NN-1:0] b, input bit bp);
    for (int k = 0; k < NN; k++) push(a[k*W +: W], bp);
    for (int k = 0; k < NN; k++) push(b[k*W +: W], bp);
  endtask

  // Returns the accepted element; stable=0 if data or strobe moved while ack was held low.
  task automatic pop(output logic [31:0] d, output bit stable, input bit bp);
    int guard;
    logic [31:0] d0;
    guard  = 0;
    stable = 1'b1;
    while (bus.out_store_stb !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (bus.out_store_stb !== 1'b1) begin
      d = 'x;
    end else begin
      if (bp) while ($urandom_range(0, 1) == 1) begin
        d0 = bus.out_store_data;
        bus.in_store_ack = 1'b0;
        @(negedge clk);
        if (bus.out_store_data !== d0 || bus.out_store_stb !== 1'b1) stable = 1'b0;
      end
      d = bus.out_store_data;
      bus.in_store_ack = 1'b1;
      @(negedge clk);
      bus.in_store_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (bus.out_load_ack !== 1'b1 || bus.out_store_stb !== 1'b0 || bus.out_core_start !== 1'b0 ||
        bus.out_busy !== 1'b0 || bus.out_store_data !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: ack=%b stb=%b start=%b busy=%b data=%h required 1 0 0 0 0",
               bus.out_load_ack, bus.out_store_stb, bus.out_core_start, bus.out_busy, bus.out_store_data);
    end
    vectors++;
    if (bus.out_matrix_a !== '0 || bus.out_matrix_b !== '0) begin
      miscompares++;
      $display("FAIL reset_bufs: a=%h b=%h required 0", bus.out_matrix_a, bus.out_matrix_b);
    end
    @(negedge clk);
    rst = 1'b0;
    push(F1, 1'b0);
    vectors++;
    if (bus.out_matrix_a !== {96'h0, F1}) begin
      miscompares++;
      $display("FAIL reset_first_load: a=%h required %h", bus.out_matrix_a, {96'h0, F1});
    end
    do_reset();
  endtask

  task automatic test_identity();
    logic [31:0] d;
    bit st;
    int s0;
    logic [31:0] exp_c [4];
    exp_c = '{F1, F2, F3, F4};
    s0 = start_cnt;
    load_job({F1, F0, F0, F1}, {F4, F3, F2, F1}, 1'b0);
    vectors++;
    if (bus.out_core_start !== 1'b1 || bus.out_load_ack !== 1'b0 || bus.out_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ident_start: start=%b ack=%b busy=%b required 1 0 1",
               bus.out_core_start, bus.out_load_ack, bus.out_busy);
    end
    @(negedge clk);
    vectors++;
    if (bus.out_core_start !== 1'b0 || bus.out_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ident_start_width: start=%b busy=%b required 0 1", bus.out_core_start, bus.out_busy);
    end
    for (int k = 0; k < NN; k++) begin
      pop(d, st, 1'b0);
      vectors++;
      if (d !== exp_c[k]) begin
        miscompares++;
        $display("FAIL ident_c%0d: got %h required %h", k, d, exp_c[k]);
      end
    end
    vectors++;
    if (bus.out_load_ack !== 1'b1 || bus.out_busy !== 1'b0 || bus.out_store_stb !== 1'b0 ||
        start_cnt - s0 !== 1) begin
      miscompares++;
      $display("FAIL ident_end: ack=%b busy=%b stb=%b starts=%0d required 1 0 0 1",
               bus.out_load_ack, bus.out_busy, bus.out_store_stb, start_cnt - s0);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    bit st;
    logic [31:0] exp_c [4];
    exp_c = '{F3, F4, F1, F2};
    load_job({F0, F1, F1, F0}, {F4, F3, F2, F1}, 1'b1);
    for (int k = 0; k < NN; k++) begin
      pop(d, st, 1'b1);
      vectors++;
      if (d !== exp_c[k] || st !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_c%0d: got %h stable=%b required %h stable=1", k, d, st, exp_c[k]);
      end
    end
    vectors++;
    if (bus.out_load_ack !== 1'b1 || bus.out_store_stb !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_end: ack=%b stb=%b required 1 0", bus.out_load_ack, bus.out_store_stb);
    end
  endtask

  task automatic test_out_of_phase();
    logic [31:0] d;
    bit st;
    bit ack_bad;
    int guard;
    logic [31:0] exp_c [4];
    exp_c = '{F5, F6, F7, F8};
    ack_bad = 1'b0;
    guard = 0;
    load_job({F1, F0, F0, F1}, {F8, F7, F6, F5}, 1'b0);
    bus.in_load_data = 32'hDEAD_BEEF;
    bus.in_load_stb  = 1'b1;
    while (bus.out_store_stb !== 1'b1 && guard < 50) begin
      if (bus.out_load_ack !== 1'b0) ack_bad = 1'b1;
      @(negedge clk);
      guard++;
    end
    for (int k = 0; k < NN; k++) begin
      if (bus.out_load_ack !== 1'b0) ack_bad = 1'b1;
      pop(d, st, 1'b0);
      vectors++;
      if (d !== exp_c[k]) begin
        miscompares++;
        $display("FAIL oop_c%0d: got %h required %h", k, d, exp_c[k]);
      end
    end
    vectors++;
    if (ack_bad) begin
      miscompares++;
      $display("FAIL oop_ack: ack went high outside load, required 0");
    end
    vectors++;
    if (bus.out_matrix_a !== {F1, F0, F0, F1} || bus.out_matrix_b !== {F8, F7, F6, F5}) begin
      miscompares++;
      $display("FAIL oop_bufs: a=%h b=%h required %h %h", bus.out_matrix_a, bus.out_matrix_b,
               {F1, F0, F0, F1}, {F8, F7, F6, F5});
    end
    bus.in_load_stb = 1'b0;
  endtask

  task automatic test_spurious_done();
    logic [31:0] d;
    bit st;
    logic [31:0] exp_c [4];
    exp_c = '{F5, F6, F7, F8};
    done_len = 3;
    for (int k = 0; k < NN; k++) push(k == 0 || k == 3 ? F1 : F0, 1'b0);
    push(F5, 1'b0);
    push(F6, 1'b0);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    vectors++;
    if (bus.out_load_ack !== 1'b1 || bus.out_store_stb !== 1'b0 || bus.out_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL spur_loadb: ack=%b stb=%b busy=%b required 1 0 0",
               bus.out_load_ack, bus.out_store_stb, bus.out_busy);
    end
    push(F7, 1'b0);
    push(F8, 1'b0);
    vectors++;
    if (bus.out_core_start !== 1'b1) begin
      miscompares++;
      $display("FAIL spur_start: start=%b required 1", bus.out_core_start);
    end
    for (int k = 0; k < NN; k++) begin
      pop(d, st, 1'b0);
      vectors++;
      if (d !== exp_c[k]) begin
        miscompares++;
        $display("FAIL spur_c%0d: got %h required %h", k, d, exp_c[k]);
      end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.out_store_stb !== 1'b0 || bus.out_load_ack !== 1'b1 || bus.out_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL spur_end: stb=%b ack=%b busy=%b required 0 1 0",
               bus.out_store_stb, bus.out_load_ack, bus.out_busy);
    end
    done_len = 1;
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] d;
    bit st;
    logic [31:0] exp_c [4];
    exp_c = '{F7, F8, F5, F6};
    load_job({F1, F0, F0, F1}, {F4, F3, F2, F1}, 1'b0);
    for (int k = 0; k < 2; k++) begin
      pop(d, st, 1'b0);
      vectors++;
      if (d !== (k == 0 ? F1 : F2)) begin
        miscompares++;
        $display("FAIL rms_pre_c%0d: got %h required %h", k, d, (k == 0 ? F1 : F2));
      end
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.out_store_stb !== 1'b0 || bus.out_busy !== 1'b0 || bus.out_load_ack !== 1'b1 ||
        bus.out_matrix_a !== '0) begin
      miscompares++;
      $display("FAIL rms_abort: stb=%b busy=%b ack=%b a=%h required 0 0 1 0",
               bus.out_store_stb, bus.out_busy, bus.out_load_ack, bus.out_matrix_a);
    end
    @(negedge clk);
    rst = 1'b0;
    load_job({F0, F1, F1, F0}, {F8, F7, F6, F5}, 1'b0);
    for (int k = 0; k < NN; k++) begin
      pop(d, st, 1'b0);
      vectors++;
      if (d !== exp_c[k]) begin
        miscompares++;
        $display("FAIL rms_c%0d: got %h required %h", k, d, exp_c[k]);
      end
    end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    start_cnt        = 0;
    done_len         = 1;
    force_done       = 1'b0;
    rst              = 1'b0;
    bus.in_load_data = '0;
    bus.in_load_stb  = 1'b0;
    bus.in_store_ack = 1'b0;
    test_reset();
    test_identity();
    test_backpressure();
    test_out_of_phase();
    test_spurious_done();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
